lsu_io_ctrl: RTL
================

# lsu_io_ctrl

Parametrised load/store-unit I/O controller: the successor to the single-purpose LSU write-buffer decoder. It decodes `i_lsu_addr` into data-memory, output-peripheral and input-peripheral regions, and owns a bank of byte-writable output registers. It also synchronises the external input channels and counts illegal store attempts. It sits between the LSU address/store-data path and the data memory and board I/O (LEDs, HEX, LCD, switches, keys) of the single-cycle core.

## Interface

Parameters:
- `NUM_OUT`, default 8, number of 32-bit output channels, legal range 1..16.
- `NUM_IN`, default 4, number of 32-bit input channels, legal range 1..16.
- `SYNC_STAGES`, default 2, flop stages per input channel, legal range 2..4.

Ports:
- `i_clk`  in  1  single clock; all state updates on its rising edge.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_lsu_addr`  in  32  byte address from the LSU.
- `i_lsu_wren`  in  1  store strobe for the current cycle.
- `i_st_data`  in  32  store data.
- `i_bmask`  in  4  byte enables; bit k enables byte k of `i_st_data`.
- `i_io_in`  in  NUM_IN*32  asynchronous external inputs; channel k is bits [32k+31:32k].
- `o_io_out`  out  NUM_OUT*32  output registers, same packing as `i_io_in`.
- `o_ld_io_data`  out  32  load data for the I/O regions.
- `o_dmem_sel`  out  1  address hits data memory.
- `o_dmem_wren`  out  1  equals `o_dmem_sel & i_lsu_wren`.
- `o_io_sel`  out  1  address hits an implemented I/O channel; this is the LSU load-mux select.
- `o_addr_err`  out  1  current access is illegal.
- `o_err_cnt`  out  8  saturating count of illegal stores.

## Operation

Address decode is combinational.
- **DMEM:** `addr[31:14]==0` and `addr[13]==1`, i.e. 0x2000–0x3FFF.
- **OUT:** `addr[31:12]==0x00007`, `addr[11:8]==0`, and `addr[7:4] < NUM_OUT`. Channel index is `addr[7:4]`, so channel k lives at 0x7000 + 0x10·k.
- **IN:** `addr[31:12]==0x00007`, `addr[11:8]==0x8`, and `addr[7:4] < NUM_IN`. Channel k lives at 0x7800 + 0x10·k.
- `addr[3:0]` is ignored inside a slot: all 16 bytes of a slot alias the same word.
- Only one region can hit at a time.

Output-register stores:
- Channel k updates at the clock edge when `i_lsu_wren` is high, the address hits OUT channel k and `i_rst_n` is high.
- Only the bytes enabled in `i_bmask` are written; other bytes keep their value.
- `i_bmask==0` is a legal no-op store.

Input synchronisation:
- Each input channel passes through `SYNC_STAGES` flops.
- The last stage is the readable value.

Loads:
- OUT hit: `o_ld_io_data` returns the register for the addressed channel.
- IN hit: it returns the last synchroniser stage for the addressed channel.
- Any other address: it returns 0.
- Loads are independent of `i_lsu_wren`.

Illegal access (`o_addr_err`):
- High when the address hits none of DMEM, OUT or IN. This includes an unimplemented channel index and any 0x7xxx address outside the two sub-ranges.
- Also high when `i_lsu_wren` is set and the address hits IN (input channels are read-only).
- An illegal store changes no state except the error counter.

Error counter (`o_err_cnt`):
- Increments by 1 at each edge where `i_lsu_wren & o_addr_err`.
- Saturates at 255.
- Only reset clears it.

## Timing

- Decode outputs and `o_ld_io_data` are combinational from the address and current register state. Load latency is 0 cycles, as the single-cycle core requires.
- A store to OUT is visible on `o_io_out` and on a read-back of the same address from the cycle after the store edge.
- A change on `i_io_in` that is stable before edge N is readable after edge N+SYNC_STAGES−1.
- Reset values (while `i_rst_n` is low at an edge, and after it):
  - all `o_io_out` bits 0;
  - all synchroniser flops 0;
  - `o_err_cnt` = 0.
- Reset overrides a simultaneous store: the register ends at 0.
- Reset asserted mid-sequence discards the store in that cycle.
- A store and a load to the same OUT address in one cycle: the load returns the old value.

## Test plan

- **Reset:** hold `i_rst_n`=0 for 2 cycles with `i_lsu_wren`=1, addr 0x7000, data 0xFFFFFFFF, mask 0xF → `o_io_out` all 0 and `o_err_cnt`=0 after release.
- **Byte-enable store:**
  - store 0xDEADBEEF with mask 0xF to 0x7010 → channel 1 reads 0xDEADBEEF next cycle;
  - then store 0x00000011 with mask 0x1 → channel 1 reads 0xDEADBE11;
  - other channels stay 0.
- **Decode:** with `i_lsu_wren`=1, check `dmem_sel` / `dmem_wren` / `io_sel` / `addr_err`:

  | Address | dmem_sel | dmem_wren | io_sel | addr_err |
  |---|---|---|---|---|
  | 0x201F | 1 | 1 | 0 | 0 |
  | 0x30F0 | 1 | 1 | 0 | 0 |
  | 0x4000 | 0 | 0 | 0 | 1 |
  | 0x70F0 (NUM_OUT=8) | 0 | 0 | 0 | 1 |
  | 0x7010 | 0 | 0 | 1 | 0 |

  With `i_lsu_wren`=0, address 0x4000 gives `addr_err`=1 and `o_err_cnt` does not increase.
- **Input sync:** drive channel 2 of `i_io_in` to 0x12345678 and read 0x7820 each cycle → reads 0 until SYNC_STAGES edges have passed, then 0x12345678. A store to 0x7820 leaves that value unchanged and raises `o_err_cnt` by 1.
- **Counter saturation:** 300 consecutive illegal stores to 0x4000 → `o_err_cnt` reaches 255 and holds. A following legal store to 0x7000 leaves it at 255.
- **Parameter sweep:** with NUM_OUT=1, NUM_IN=1, SYNC_STAGES=3:
  - 0x7010 is illegal; 0x7000 is legal;
  - input latency is 3 edges.

Source files
------------

// File: rtl/lsu_io_ctrl.sv
// rtl/lsu_io_ctrl.sv - LSU address decoder, byte-writable output registers, input synchronisers, illegal-store counter
module lsu_io_ctrl #(
    parameter int NUM_OUT     = 8,
    parameter int NUM_IN      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [31:0]           i_lsu_addr,
    input  logic                  i_lsu_wren,
    input  logic [31:0]           i_st_data,
    input  logic [3:0]            i_bmask,
    input  logic [NUM_IN*32-1:0]  i_io_in,
    output logic [NUM_OUT*32-1:0] o_io_out,
    output logic [31:0]           o_ld_io_data,
    output logic                  o_dmem_sel,
    output logic                  o_dmem_wren,
    output logic                  o_io_sel,
    output logic                  o_addr_err,
    output logic [7:0]            o_err_cnt
);

    localparam logic [4:0] OUT_LIM = 5'(NUM_OUT);
    localparam logic [4:0] IN_LIM  = 5'(NUM_IN);

    logic [31:0]          out_q [NUM_OUT];
    logic [31:0]          out_d [NUM_OUT];
    logic [NUM_IN*32-1:0] sync_q [SYNC_STAGES];
    logic [7:0]           err_cnt_q;
    logic [7:0]           err_cnt_d;

    logic [3:0] slot;
    logic       io_page;
    logic       out_hit;
    logic       in_hit;
    logic       unused_addr_lsbs;

    // addr[3:0] only selects a byte inside a slot; every byte aliases the same word
    assign unused_addr_lsbs = ^i_lsu_addr[3:0];

    assign slot       = i_lsu_addr[7:4];
    assign io_page    = (i_lsu_addr[31:12] == 20'h00007);
    assign o_dmem_sel = (i_lsu_addr[31:14] == 18'd0) && i_lsu_addr[13];
    assign out_hit    = io_page && (i_lsu_addr[11:8] == 4'h0) && ({1'b0, slot} < OUT_LIM);
    assign in_hit     = io_page && (i_lsu_addr[11:8] == 4'h8) && ({1'b0, slot} < IN_LIM);

    assign o_dmem_wren = o_dmem_sel & i_lsu_wren;
    assign o_io_sel    = out_hit | in_hit;
    assign o_addr_err  = ~(o_dmem_sel | out_hit | in_hit) | (i_lsu_wren & in_hit);
    assign o_err_cnt   = err_cnt_q;

    always_comb begin
        o_ld_io_data = 32'd0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (out_hit && slot == 4'(k)) begin
                o_ld_io_data = out_q[k];
            end
        end
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_hit && slot == 4'(k)) begin
                o_ld_io_data = sync_q[SYNC_STAGES-1][32*k +: 32];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_OUT; k++) begin
            out_d[k] = out_q[k];
            if (i_lsu_wren && out_hit && slot == 4'(k)) begin
                for (int b = 0; b < 4; b++) begin
                    if (i_bmask[b]) begin
                        out_d[k][8*b +: 8] = i_st_data[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (i_lsu_wren && o_addr_err && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                out_q[k] <= 32'd0;
            end
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            err_cnt_q <= 8'd0;
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                out_q[k] <= out_d[k];
            end
            sync_q[0] <= i_io_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            err_cnt_q <= err_cnt_d;
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out_pack
        assign o_io_out[32*g +: 32] = out_q[g];
    end

endmodule
